// File: rtl/gam_learning_sequencer_pkg.sv
// Shared constants and types for the GAM learning/recall sequencer.
package gam_learning_sequencer_pkg;

   localparam int unsigned CLASS_COUNT = 4;
   localparam int unsigned NODE_COUNT  = 16;
   localparam int unsigned X_W         = 32;
   localparam int unsigned ACK_TIMEOUT = 64;

   // Index widths: 1-based indices with 0 meaning "none"
   localparam int unsigned CLASS_W     = $clog2(CLASS_COUNT + 1);
   localparam int unsigned NODE_W      = $clog2(NODE_COUNT + 1);
   // Scan cursor must reach CLASS_COUNT+1 to detect the end of a pass
   localparam int unsigned CURSOR_W    = $clog2(CLASS_COUNT + 2);
   // Zero-based array index widths
   localparam int unsigned CLASS_IDX_W = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
   localparam int unsigned NODE_IDX_W  = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;

   typedef logic [X_W-1:0] node_vector_T;

   typedef enum logic {
      LEARNING = 1'b0,
      RECALL   = 1'b1
   } LEARNING_RECALL_T;

   typedef enum logic {
      READY = 1'b0,
      WAIT  = 1'b1
   } READY_WAIT_T;

   typedef enum logic [3:0] {
      StIdle,
      StScan,
      StIssue,
      StAck,
      StDoneWait,
      StFinish,
      StRIdle,
      StRHold,
      StErr
   } SEQ_STATE_T;

   // A zero hold length still presents the cue for one cycle
   function automatic logic [7:0] hold_init(input logic [7:0] tk);
      return (tk == 8'd0) ? 8'd1 : tk;
   endfunction

endpackage

// File: rtl/gam_pattern_store.sv
// Training pattern store: class x node register array, per-class high-water
// node counts, load validation and a combinational read port.
module gam_pattern_store
   import gam_learning_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                ld_open,
   input  logic                ld_valid,
   input  logic [CLASS_W-1:0]  ld_class,
   input  logic [NODE_W-1:0]   ld_node,
   input  logic [X_W-1:0]      ld_data,
   output logic                ld_reject,
   input  logic [CURSOR_W-1:0] rd_class,
   input  logic [NODE_W-1:0]   rd_node,
   output logic [X_W-1:0]      rd_data,
   output logic [NODE_W-1:0]   rd_count
);

   localparam logic [CLASS_W-1:0]  LdClassMax = CLASS_W'(CLASS_COUNT);
   localparam logic [NODE_W-1:0]   NodeMax    = NODE_W'(NODE_COUNT);
   localparam logic [CURSOR_W-1:0] RdClassMax = CURSOR_W'(CLASS_COUNT);

   logic [X_W-1:0]         store_q [CLASS_COUNT][NODE_COUNT];
   logic [NODE_W-1:0]      count_q [CLASS_COUNT];
   logic                   reject_q;
   logic                   ld_ok;
   logic                   rd_in_range;
   logic [CLASS_IDX_W-1:0] wr_ci;
   logic [CLASS_IDX_W-1:0] rd_ci;
   logic [NODE_IDX_W-1:0]  wr_ni;
   logic [NODE_IDX_W-1:0]  rd_ni;

   // Load validation and 1-based to 0-based index conversion
   always_comb begin
      ld_ok = ld_valid && ld_open && (ld_data != '0) &&
              (ld_class != '0) && (ld_class <= LdClassMax) &&
              (ld_node != '0) && (ld_node <= NodeMax);
      wr_ci = CLASS_IDX_W'(ld_class - CLASS_W'(1));
      wr_ni = NODE_IDX_W'(ld_node - NODE_W'(1));
      rd_ci = CLASS_IDX_W'(rd_class - CURSOR_W'(1));
      rd_ni = NODE_IDX_W'(rd_node - NODE_W'(1));
      rd_in_range = (rd_class != '0) && (rd_class <= RdClassMax);
   end

   // Pattern array write; contents need no reset
   always_ff @(posedge clk) begin
      if (ld_ok) begin
         store_q[wr_ci][wr_ni] <= ld_data;
      end
   end

   // Per-class counts track the highest node loaded; reject pulses one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(CLASS_COUNT); i++) begin
            count_q[i] <= '0;
         end
         reject_q <= 1'b0;
      end else begin
         reject_q <= ld_valid && !ld_ok;
         if (ld_ok && (ld_node > count_q[wr_ci])) begin
            count_q[wr_ci] <= ld_node;
         end
      end
   end

   assign ld_reject = reject_q;
   assign rd_data   = store_q[rd_ci][rd_ni];
   // Out-of-range cursor reads as an empty class so the scan skips it
   assign rd_count  = rd_in_range ? count_q[rd_ci] : '0;

endmodule

// File: rtl/gam_learning_sequencer.sv
// Learning/recall sequencer for Memory_Layer: replays stored training
// patterns over the ready/wait handshake, then serves timed recall cues.
module gam_learning_sequencer
   import gam_learning_sequencer_pkg::*;
#(
   parameter int unsigned AckTimeout = ACK_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_valid,
   input  logic [CLASS_W-1:0] ld_class,
   input  logic [NODE_W-1:0]  ld_node,
   input  logic [X_W-1:0]     ld_data,
   output logic               ld_reject,
   input  logic               start,
   input  logic [7:0]         tk,
   input  logic               recall_req,
   input  logic [X_W-1:0]     recall_pattern,
   output logic               recall_ack,
   output logic [X_W-1:0]     x,
   output logic [31:0]        c,
   output logic               learning_done,
   output LEARNING_RECALL_T   learning_recall,
   input  READY_WAIT_T        ready_wait,
   output logic               busy,
   output logic               error,
   output logic [15:0]        issued_count
);

   localparam int unsigned         TmoW    = $clog2(AckTimeout + 1);
   localparam logic [TmoW-1:0]     TmoLast = TmoW'(AckTimeout - 1);
   localparam logic [CURSOR_W-1:0] ClsLast = CURSOR_W'(CLASS_COUNT);

   SEQ_STATE_T         state_q, state_d;
   logic [CURSOR_W-1:0] cls_q, cls_d;
   logic [NODE_W-1:0]  node_q, node_d;
   logic [15:0]        issued_q, issued_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [31:0]        c_q, c_d;
   logic               done_q, done_d;
   LEARNING_RECALL_T   lr_q, lr_d;
   logic               err_q, err_d;
   logic [TmoW-1:0]    tmo_q, tmo_d;
   logic [7:0]         hold_q, hold_d;
   logic               waiting;
   logic               ld_open;
   logic [X_W-1:0]     rd_data;
   logic [NODE_W-1:0]  rd_count;

   assign ld_open = (state_q == StIdle) || (state_q == StRIdle);

   gam_pattern_store u_store (
      .clk      (clk),
      .reset    (reset),
      .ld_open  (ld_open),
      .ld_valid (ld_valid),
      .ld_class (ld_class),
      .ld_node  (ld_node),
      .ld_data  (ld_data),
      .ld_reject(ld_reject),
      .rd_class (cls_q),
      .rd_node  (node_q),
      .rd_data  (rd_data),
      .rd_count (rd_count)
   );

   // Next-state and datapath updates for the learning/recall sequence
   always_comb begin
      state_d  = state_q;
      cls_d    = cls_q;
      node_d   = node_q;
      issued_d = issued_q;
      x_d      = x_q;
      c_d      = c_q;
      done_d   = done_q;
      lr_d     = lr_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      hold_d   = hold_q;
      waiting  = 1'b0;

      case (state_q)
         StIdle, StRIdle: begin
            if (start) begin
               state_d  = StScan;
               cls_d    = CURSOR_W'(1);
               node_d   = NODE_W'(1);
               issued_d = '0;
               done_d   = 1'b0;
               lr_d     = LEARNING;
            end else if ((state_q == StRIdle) && recall_req && (recall_pattern != '0)) begin
               state_d = StRHold;
               x_d     = recall_pattern;
               hold_d  = hold_init(tk);
            end
         end
         StScan: begin
            if (cls_q > ClsLast) begin
               state_d = StFinish;
            end else if ((rd_count != '0) && (node_q <= rd_count)) begin
               state_d = StIssue;
               tmo_d   = '0;
            end else begin
               cls_d  = cls_q + 1'b1;
               node_d = NODE_W'(1);
            end
         end
         StIssue: begin
            if (ready_wait == READY) begin
               state_d = StAck;
               x_d     = rd_data;
               c_d     = 32'(cls_q);
               tmo_d   = '0;
            end else begin
               waiting = 1'b1;
            end
         end
         StAck: begin
            if (ready_wait == WAIT) begin
               state_d = StDoneWait;
               tmo_d   = '0;
            end else begin
               waiting = 1'b1;
            end
         end
         StDoneWait: begin
            if (ready_wait == READY) begin
               state_d  = StScan;
               issued_d = issued_q + 1'b1;
               if (node_q >= rd_count) begin
                  cls_d  = cls_q + 1'b1;
                  node_d = NODE_W'(1);
               end else begin
                  node_d = node_q + 1'b1;
               end
            end else begin
               waiting = 1'b1;
            end
         end
         StFinish: begin
            state_d = StRIdle;
            done_d  = 1'b1;
            lr_d    = RECALL;
         end
         StRHold: begin
            if (hold_q <= 8'd1) begin
               state_d = StRIdle;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         StErr: begin
            state_d = StErr;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Shared handshake watchdog for ISSUE, ACK and DONE_WAIT
      if (waiting) begin
         if (tmo_q >= TmoLast) begin
            state_d = StErr;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cls_q    <= '0;
         node_q   <= '0;
         issued_q <= '0;
         x_q      <= '0;
         c_q      <= '0;
         done_q   <= 1'b0;
         lr_q     <= LEARNING;
         err_q    <= 1'b0;
         tmo_q    <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         cls_q    <= cls_d;
         node_q   <= node_d;
         issued_q <= issued_d;
         x_q      <= x_d;
         c_q      <= c_d;
         done_q   <= done_d;
         lr_q     <= lr_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
         hold_q   <= hold_d;
      end
   end

   assign x               = x_q;
   assign c               = c_q;
   assign learning_done   = done_q;
   assign learning_recall = lr_q;
   assign error           = err_q;
   assign issued_count    = issued_q;
   assign busy            = !ld_open;
   // Ack is asserted during the final cycle of the hold
   assign recall_ack      = (state_q == StRHold) && (hold_q == 8'd1);

endmodule

// File: tb/tb_gam_learning_sequencer.sv
// Directed bench for gam_learning_sequencer: load tables, learning passes
// against a periodic Memory_Layer model, recall timing, timeout and resets.
module tb_gam_learning_sequencer;
   import gam_learning_sequencer_pkg::*;

   typedef struct {
      logic [2:0]  cls;
      logic [4:0]  node;
      logic [31:0] data;
      logic        exp_rej;
   } ld_vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             ld_valid;
   logic [2:0]       ld_class;
   logic [4:0]       ld_node;
   logic [31:0]      ld_data;
   logic             ld_reject;
   logic             start;
   logic [7:0]       tk;
   logic             recall_req;
   logic [31:0]      recall_pattern;
   logic             recall_ack;
   logic [31:0]      x;
   logic [31:0]      c;
   logic             learning_done;
   LEARNING_RECALL_T learning_recall;
   READY_WAIT_T      ready_wait;
   logic             busy;
   logic             error;
   logic [15:0]      issued_count;

   logic             hang = 1'b0;
   logic [1:0]       phase = 2'd0;

   int               total = 0;
   int               bad = 0;
   logic [31:0]      cap_x[$];
   int               cap_c[$];
   logic [31:0]      last_x;
   logic             ack_seen;

   ld_vec_t          tab1[13];
   ld_vec_t          tab2[6];
   logic [31:0]      exp1_x[8];
   logic [31:0]      exp2_x[6];
   int               exp2_c[6];

   always #5 clk = ~clk;

   // Memory_Layer model: READY one cycle, then WAIT two cycles, repeating
   always @(posedge clk) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
   assign ready_wait = (hang || (phase != 2'd0)) ? WAIT : READY;

   gam_learning_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .ld_valid       (ld_valid),
      .ld_class       (ld_class),
      .ld_node        (ld_node),
      .ld_data        (ld_data),
      .ld_reject      (ld_reject),
      .start          (start),
      .tk             (tk),
      .recall_req     (recall_req),
      .recall_pattern (recall_pattern),
      .recall_ack     (recall_ack),
      .x              (x),
      .c              (c),
      .learning_done  (learning_done),
      .learning_recall(learning_recall),
      .ready_wait     (ready_wait),
      .busy           (busy),
      .error          (error),
      .issued_count   (issued_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Tick and log every change of x as one issued pattern
   task automatic step;
      tick();
      if (recall_ack) ack_seen = 1'b1;
      if (x !== last_x) begin
         cap_x.push_back(x);
         cap_c.push_back(int'(c));
         last_x = x;
      end
   endtask

   task automatic pulse_start;
      cap_x.delete();
      cap_c.delete();
      last_x   = x;
      ack_seen = 1'b0;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic run_to_done(input string name);
      int n = 0;
      while (!learning_done && n < 400) begin
         step();
         n++;
      end
      chk({name, "_done"}, 32'(learning_done), 32'd1);
   endtask

   task automatic do_load(input ld_vec_t v, input string name);
      ld_valid = 1'b1;
      ld_class = v.cls;
      ld_node  = v.node;
      ld_data  = v.data;
      tick();
      ld_valid = 1'b0;
      chk(name, 32'(ld_reject), 32'(v.exp_rej));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_x"}, x, 32'd0);
      chk({tag, "_c"}, c, 32'd0);
      chk({tag, "_done"}, 32'(learning_done), 32'd0);
      chk({tag, "_mode"}, 32'(learning_recall), 32'(LEARNING));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_ack"}, 32'(recall_ack), 32'd0);
      chk({tag, "_rej"}, 32'(ld_reject), 32'd0);
      chk({tag, "_issued"}, 32'(issued_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "bench watchdog");
   end

   initial begin
      tab1[0]  = '{3'd1, 5'd1,  32'h0000_0003, 1'b0};
      tab1[1]  = '{3'd1, 5'd2,  32'h0000_0400, 1'b0};
      tab1[2]  = '{3'd1, 5'd3,  32'h0007_0005, 1'b0};
      tab1[3]  = '{3'd1, 5'd4,  32'h0000_0101, 1'b0};
      tab1[4]  = '{3'd1, 5'd5,  32'h0c0b_0a09, 1'b0};
      tab1[5]  = '{3'd1, 5'd6,  32'h0000_0604, 1'b0};
      tab1[6]  = '{3'd1, 5'd7,  32'h0006_0002, 1'b0};
      tab1[7]  = '{3'd1, 5'd8,  32'h0000_0202, 1'b0};
      tab1[8]  = '{3'd1, 5'd9,  32'h0000_0000, 1'b1};
      tab1[9]  = '{3'd1, 5'd0,  32'h0000_dead, 1'b1};
      tab1[10] = '{3'd5, 5'd1,  32'h0000_beef, 1'b1};
      tab1[11] = '{3'd0, 5'd2,  32'h0000_0001, 1'b1};
      tab1[12] = '{3'd2, 5'd17, 32'h0000_0005, 1'b1};
      for (int i = 0; i < 8; i++) exp1_x[i] = tab1[i].data;

      tab2[0] = '{3'd1, 5'd1, 32'h0000_0011, 1'b0};
      tab2[1] = '{3'd1, 5'd2, 32'h0000_0012, 1'b0};
      tab2[2] = '{3'd1, 5'd3, 32'h0000_0013, 1'b0};
      tab2[3] = '{3'd3, 5'd1, 32'h0000_0031, 1'b0};
      tab2[4] = '{3'd3, 5'd2, 32'h0000_0032, 1'b0};
      tab2[5] = '{3'd3, 5'd3, 32'h0000_0033, 1'b0};
      for (int i = 0; i < 6; i++) begin
         exp2_x[i] = tab2[i].data;
         exp2_c[i] = int'(tab2[i].cls);
      end

      reset = 1'b1; ld_valid = 1'b0; ld_class = '0; ld_node = '0; ld_data = '0;
      start = 1'b0; tk = '0; recall_req = 1'b0; recall_pattern = '0;
      ack_seen = 1'b0; last_x = '0;
      tick();
      tick();
      check_reset_outputs("rst");
      reset = 1'b0;

      // Loads: eight accepted class-1 patterns, then refused ones
      for (int i = 0; i < 13; i++) do_load(tab1[i], $sformatf("load1_%0d", i));

      pulse_start();
      run_to_done("pass1");
      chk("pass1_n", 32'(cap_x.size()), 32'd8);
      for (int i = 0; i < 8 && i < cap_x.size(); i++) begin
         chk($sformatf("pass1_x%0d", i), cap_x[i], exp1_x[i]);
         chk($sformatf("pass1_c%0d", i), 32'(cap_c[i]), 32'd1);
      end
      chk("pass1_issued", 32'(issued_count), 32'd8);
      chk("pass1_mode", 32'(learning_recall), 32'(RECALL));
      chk("pass1_busy", 32'(busy), 32'd0);

      // Recall with tk=4: cue held four cycles, ack on the fourth
      recall_req = 1'b1; recall_pattern = 32'h0007_0005; tk = 8'd4;
      tick();
      recall_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("rc4_x%0d", i), x, 32'h0007_0005);
         chk($sformatf("rc4_ack%0d", i), 32'(recall_ack), 32'(i == 4));
         tick();
      end
      chk("rc4_ack_after", 32'(recall_ack), 32'd0);
      chk("rc4_busy_after", 32'(busy), 32'd0);

      // tk=0 behaves as a one-cycle hold
      recall_req = 1'b1; recall_pattern = 32'h1234_5678; tk = 8'd0;
      tick();
      recall_req = 1'b0;
      chk("rc0_x", x, 32'h1234_5678);
      chk("rc0_ack", 32'(recall_ack), 32'd1);
      tick();
      chk("rc0_ack_after", 32'(recall_ack), 32'd0);

      // Zero cue is ignored
      recall_req = 1'b1; recall_pattern = 32'd0; tk = 8'd2;
      ack_seen = 1'b0;
      tick();
      recall_req = 1'b0;
      chk("rcz_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (recall_ack) ack_seen = 1'b1;
      end
      chk("rcz_noack", 32'(ack_seen), 32'd0);
      chk("rcz_x", x, 32'h1234_5678);

      // start wins over a simultaneous recall request
      recall_req = 1'b1; recall_pattern = 32'h0000_abcd; tk = 8'd2;
      pulse_start();
      recall_req = 1'b0;
      chk("race_busy", 32'(busy), 32'd1);
      chk("race_done", 32'(learning_done), 32'd0);
      chk("race_mode", 32'(learning_recall), 32'(LEARNING));
      run_to_done("race");
      chk("race_noack", 32'(ack_seen), 32'd0);
      chk("race_n", 32'(cap_x.size()), 32'd8);
      chk("race_issued", 32'(issued_count), 32'd8);

      // Reset in the middle of a pass
      pulse_start();
      step();
      step();
      step();
      reset = 1'b1;
      tick();
      check_reset_outputs("midrst");
      reset = 1'b0;

      // Classes 1 and 3 populated, class 2 empty
      for (int i = 0; i < 6; i++) do_load(tab2[i], $sformatf("load2_%0d", i));
      pulse_start();
      ld_valid = 1'b1; ld_class = 3'd2; ld_node = 5'd1; ld_data = 32'h77;
      step();
      ld_valid = 1'b0;
      chk("busy_load_rej", 32'(ld_reject), 32'd1);
      run_to_done("pass2");
      chk("pass2_n", 32'(cap_x.size()), 32'd6);
      for (int i = 0; i < 6 && i < cap_x.size(); i++) begin
         chk($sformatf("pass2_x%0d", i), cap_x[i], exp2_x[i]);
         chk($sformatf("pass2_c%0d", i), 32'(cap_c[i]), 32'(exp2_c[i]));
      end
      chk("pass2_issued", 32'(issued_count), 32'd6);

      // Handshake timeout while issuing node 3 of class 1
      pulse_start();
      for (int n = 0; n < 200 && issued_count != 16'd2; n++) step();
      chk("tmo_reach2", 32'(issued_count), 32'd2);
      hang = 1'b1;
      for (int i = 0; i < 64; i++) tick();
      chk("tmo_err_early", 32'(error), 32'd0);
      tick();
      chk("tmo_err", 32'(error), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd1);
      chk("tmo_x", x, 32'h0000_0012);
      chk("tmo_c", c, 32'd1);
      hang = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("tmo_sticky", 32'(error), 32'd1);
      chk("tmo_issued_hold", 32'(issued_count), 32'd2);
      reset = 1'b1;
      tick();
      check_reset_outputs("errrst");
      reset = 1'b0;

      // Empty store after reset: FINISH after CLASS_COUNT+1 scan cycles
      pulse_start();
      for (int i = 0; i < 5; i++) tick();
      chk("empty_done_early", 32'(learning_done), 32'd0);
      tick();
      chk("empty_done", 32'(learning_done), 32'd1);
      chk("empty_mode", 32'(learning_recall), 32'(RECALL));
      chk("empty_issued", 32'(issued_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
